// File: rtl/wb_port_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of one OpenRAM channel controller.
// The grant is held for exactly one transfer, which ends on ack, on abort or on timeout.
module wb_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMEOUT_BITS   = 5
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_cyc_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [31:0]           m0_dat_i,
    input  logic [3:0]            m0_sel_i,
    output logic [31:0]           m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic                  m1_stb_i,
    input  logic                  m1_cyc_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [31:0]           m1_dat_i,
    input  logic [3:0]            m1_sel_i,
    output logic [31:0]           m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  s_stb_o,
    output logic                  s_cyc_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [31:0]           s_dat_o,
    output logic [3:0]            s_sel_o,
    input  logic [31:0]           s_dat_i,
    input  logic                  s_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2
    } state_t;

    localparam bit LP_TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TIMEOUT_BITS-1:0] LP_TLAST =
        LP_TO_EN ? TIMEOUT_BITS'(TIMEOUT_CYCLES - 1) : '0;

    state_t                  r_state;
    logic                    r_last_grant;
    logic [TIMEOUT_BITS-1:0] r_tcnt;

    logic w_req0;
    logic w_req1;
    logic w_g0;
    logic w_g1;
    logic w_cyc_g;
    logic w_req_other;
    logic w_to;

    assign w_req0      = m0_cyc_i & m0_stb_i;
    assign w_req1      = m1_cyc_i & m1_stb_i;
    assign w_g0        = (r_state == ST_G0);
    assign w_g1        = (r_state == ST_G1);
    assign w_cyc_g     = (w_g0 & m0_cyc_i) | (w_g1 & m1_cyc_i);
    assign w_req_other = (w_g0 & w_req1) | (w_g1 & w_req0);

    // An ack in the final cycle suppresses the timeout, so ack always wins.
    assign w_to = LP_TO_EN && w_cyc_g && !s_ack_i && (r_tcnt == LP_TLAST);

    always_comb begin
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        if (w_g0) begin
            s_stb_o = m0_stb_i & ~w_to;
            s_cyc_o = m0_cyc_i & ~w_to;
            s_we_o  = m0_we_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
        end else if (w_g1) begin
            s_stb_o = m1_stb_i & ~w_to;
            s_cyc_o = m1_cyc_i & ~w_to;
            s_we_o  = m1_we_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
        end
    end

    assign m0_ack_o = w_g0 & s_ack_i & s_stb_o;
    assign m1_ack_o = w_g1 & s_ack_i & s_stb_o;
    assign m0_err_o = w_g0 & w_to;
    assign m1_err_o = w_g1 & w_to;
    assign m0_dat_o = w_g0 ? s_dat_i : 32'h0;
    assign m1_dat_o = w_g1 ? s_dat_i : 32'h0;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_tcnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tcnt <= '0;
                    if (w_req0 && w_req1) begin
                        r_state <= r_last_grant ? ST_G0 : ST_G1;
                    end else if (w_req0) begin
                        r_state <= ST_G0;
                    end else if (w_req1) begin
                        r_state <= ST_G1;
                    end
                end
                ST_G0, ST_G1: begin
                    if (!w_cyc_g) begin
                        // Abort keeps last_grant so the aborting master does not lose its turn.
                        r_state <= ST_IDLE;
                        r_tcnt  <= '0;
                    end else if (s_ack_i || w_to) begin
                        r_last_grant <= w_g1;
                        r_tcnt       <= '0;
                        if (w_req_other) begin
                            r_state <= w_g0 ? ST_G1 : ST_G0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (LP_TO_EN) begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tcnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: per-cycle vector table plus hand-built timeout and reset sequences.
module tb_wb_port_arbiter;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        m0_stb_i, m0_cyc_i, m0_we_i;
    logic [31:0] m0_adr_i, m0_dat_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_dat_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_stb_i, m1_cyc_i, m1_we_i;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_dat_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_stb_o, s_cyc_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i;

    wb_port_arbiter #(
        .ADDR_WIDTH(32),
        .TIMEOUT_CYCLES(16),
        .TIMEOUT_BITS(5)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // in  = {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack}
    // out = {grant[1:0] (0 idle, 1 m0, 2 m1), s_stb, s_cyc, m0_ack, m1_ack, m0_err, m1_err}
    typedef struct {
        bit          rst;
        bit          noise;
        logic [6:0]  in;
        logic [31:0] rdat;
        logic [7:0]  out;
    } vec_t;

    typedef struct {
        int          id;
        logic [70:0] sbus;
        logic [33:0] m0;
        logic [33:0] m1;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_pass = 0;
    int   n_tot  = 0;
    int   vid    = 0;

    logic [138:0] w_all;
    assign w_all = {s_stb_o, s_cyc_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
                    m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o};

    function automatic vec_t mk(bit rst, bit noise, logic [6:0] in, logic [31:0] rdat,
                                logic [7:0] out);
        vec_t v;
        v.rst   = rst;
        v.noise = noise;
        v.in    = in;
        v.rdat  = rdat;
        v.out   = out;
        return v;
    endfunction

    task automatic chk(string name, int id, logic [159:0] act, logic [159:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s vec %0d: got %0h expected %0h", name, id, act, exp);
    endtask

    task automatic idle_inputs();
        {m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i, s_ack_i} = 7'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        chk("reset_outputs", vid, 160'(w_all), 160'(0));
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
    endtask

    task automatic apply(vec_t v);
        exp_t       e;
        exp_t       got;
        logic [1:0] g;
        if (v.rst) do_reset();
        @(posedge wb_clk_i);
        #1;
        {m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i, s_ack_i} = v.in;
        if (v.noise) begin
            m0_adr_i = $urandom;
            m0_dat_i = $urandom;
            m0_sel_i = 4'($urandom);
        end else begin
            m0_adr_i = 32'h3000_0010;
            m0_dat_i = 32'h1111_2222;
            m0_sel_i = 4'hF;
        end
        m1_adr_i = 32'h4000_0020;
        m1_dat_i = 32'hA5A5_0F0F;
        m1_sel_i = 4'b0110;
        s_dat_i  = (v.rdat != 32'h0) ? v.rdat : (32'h0BAD_0000 | 32'(vid));
        g = v.out[7:6];
        e.id = vid;
        case (g)
            2'd1:    e.sbus = {v.out[5], v.out[4], m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i};
            2'd2:    e.sbus = {v.out[5], v.out[4], m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i};
            default: e.sbus = {v.out[5], v.out[4], 1'b0, 4'h0, 32'h0, 32'h0};
        endcase
        e.m0 = {v.out[3], v.out[1], (g == 2'd1) ? s_dat_i : 32'h0};
        e.m1 = {v.out[2], v.out[0], (g == 2'd2) ? s_dat_i : 32'h0};
        sb.push_back(e);
        @(negedge wb_clk_i);
        got = sb.pop_front();
        chk("slave_port", got.id,
            160'({s_stb_o, s_cyc_o, s_we_o, s_sel_o, s_adr_o, s_dat_o}), 160'(got.sbus));
        chk("m0_port", got.id, 160'({m0_ack_o, m0_err_o, m0_dat_o}), 160'(got.m0));
        chk("m1_port", got.id, 160'({m1_ack_o, m1_err_o, m1_dat_o}), 160'(got.m1));
        vid++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        wb_rst_i = 1'b1;
        idle_inputs();
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
        s_dat_i  = '0;

        // single read from m0, ack two cycles after strobe
        tbl.push_back(mk(1, 0, 7'b000_000_0, 32'h0,         8'b00_000000));
        tbl.push_back(mk(0, 0, 7'b110_000_0, 32'h0,         8'b00_000000));
        tbl.push_back(mk(0, 0, 7'b110_000_0, 32'h0,         8'b01_110000));
        tbl.push_back(mk(0, 0, 7'b110_000_0, 32'h0,         8'b01_110000));
        tbl.push_back(mk(0, 0, 7'b110_000_1, 32'hDEADBEEF,  8'b01_111000));
        tbl.push_back(mk(0, 0, 7'b000_000_0, 32'h0,         8'b00_000000));
        // contention from reset, back-to-back handover, alternation
        tbl.push_back(mk(1, 0, 7'b110_110_0, 32'h0,         8'b00_000000));
        tbl.push_back(mk(0, 0, 7'b110_110_0, 32'h0,         8'b01_110000));
        tbl.push_back(mk(0, 0, 7'b110_110_1, 32'h0000_1234, 8'b01_111000));
        tbl.push_back(mk(0, 0, 7'b000_110_0, 32'h0,         8'b10_110000));
        tbl.push_back(mk(0, 0, 7'b000_110_1, 32'h5555_AAAA, 8'b10_110100));
        tbl.push_back(mk(0, 0, 7'b110_110_0, 32'h0,         8'b00_000000));
        tbl.push_back(mk(0, 0, 7'b110_110_1, 32'h0,         8'b01_111000));
        tbl.push_back(mk(0, 0, 7'b110_110_1, 32'h0,         8'b10_110100));
        tbl.push_back(mk(0, 0, 7'b000_000_0, 32'h0,         8'b01_000000));
        tbl.push_back(mk(0, 0, 7'b000_000_0, 32'h0,         8'b00_000000));
        // m1 write passthrough while m0 inputs toggle
        tbl.push_back(mk(1, 1, 7'b000_111_0, 32'h0,         8'b00_000000));
        tbl.push_back(mk(0, 1, 7'b110_111_0, 32'h0,         8'b10_110000));
        tbl.push_back(mk(0, 1, 7'b011_111_0, 32'h0,         8'b10_110000));
        tbl.push_back(mk(0, 1, 7'b110_111_1, 32'h600D_F00D, 8'b10_110100));
        tbl.push_back(mk(0, 1, 7'b110_000_1, 32'hCAFE_F00D, 8'b01_111000));
        tbl.push_back(mk(0, 0, 7'b000_000_0, 32'h0,         8'b00_000000));
        // m1 abort keeps its turn for the next contended request
        tbl.push_back(mk(1, 0, 7'b110_000_0, 32'h0,         8'b00_000000));
        tbl.push_back(mk(0, 0, 7'b110_000_1, 32'h0,         8'b01_111000));
        tbl.push_back(mk(0, 0, 7'b000_110_0, 32'h0,         8'b00_000000));
        tbl.push_back(mk(0, 0, 7'b000_110_0, 32'h0,         8'b10_110000));
        tbl.push_back(mk(0, 0, 7'b000_100_0, 32'h0,         8'b10_010000));
        tbl.push_back(mk(0, 0, 7'b000_110_0, 32'h0,         8'b10_110000));
        tbl.push_back(mk(0, 0, 7'b110_000_0, 32'h0,         8'b10_000000));
        tbl.push_back(mk(0, 0, 7'b110_110_0, 32'h0,         8'b00_000000));
        tbl.push_back(mk(0, 0, 7'b110_110_1, 32'h0,         8'b10_110100));
        tbl.push_back(mk(0, 0, 7'b000_000_0, 32'h0,         8'b01_000000));
        tbl.push_back(mk(0, 0, 7'b000_000_0, 32'h0,         8'b00_000000));

        foreach (tbl[i]) apply(tbl[i]);

        // timeout on m0 with m1 waiting: err in the 16th granted cycle, then m1
        apply(mk(1, 0, 7'b110_110_0, 32'h0, 8'b00_000000));
        for (int k = 1; k <= 15; k++) apply(mk(0, 0, 7'b110_110_0, 32'h0, 8'b01_110000));
        apply(mk(0, 0, 7'b110_110_0, 32'h0, 8'b01_000010));
        apply(mk(0, 0, 7'b000_110_0, 32'h0, 8'b10_110000));
        apply(mk(0, 0, 7'b000_110_1, 32'h0, 8'b10_110100));
        apply(mk(0, 0, 7'b000_000_0, 32'h0, 8'b00_000000));

        // ack in the timeout cycle wins; m0 then re-granted after one idle cycle
        apply(mk(1, 0, 7'b110_000_0, 32'h0, 8'b00_000000));
        for (int k = 1; k <= 15; k++) apply(mk(0, 0, 7'b110_000_0, 32'h0, 8'b01_110000));
        apply(mk(0, 0, 7'b110_000_1, 32'h1357_9BDF, 8'b01_111000));
        apply(mk(0, 0, 7'b110_000_0, 32'h0, 8'b00_000000));
        apply(mk(0, 0, 7'b110_000_0, 32'h0, 8'b01_110000));
        apply(mk(0, 0, 7'b000_000_0, 32'h0, 8'b01_000000));

        // asynchronous reset in the middle of a granted transfer
        apply(mk(1, 0, 7'b110_000_0, 32'h0, 8'b00_000000));
        apply(mk(0, 0, 7'b110_000_0, 32'h0, 8'b01_110000));
        #2;
        s_ack_i  = 1'b1;
        wb_rst_i = 1'b1;
        #1;
        chk("async_reset", vid, 160'(w_all), 160'(0));
        idle_inputs();
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        apply(mk(0, 0, 7'b110_110_0, 32'h0, 8'b00_000000));
        apply(mk(0, 0, 7'b110_110_0, 32'h0, 8'b01_110000));
        apply(mk(0, 0, 7'b110_110_1, 32'h0, 8'b01_111000));
        apply(mk(0, 0, 7'b000_000_0, 32'h0, 8'b10_000000));
        apply(mk(0, 0, 7'b000_000_0, 32'h0, 8'b00_000000));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
